// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the MCU-side memory access controller.
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned WR_LEAD_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    RD_DONE,
    WR_ARM,
    WR_CMD,
    WR_DONE,
    WR_GAP
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-side responder: turns MCU single-beat read/write requests into
// Avalon-MM master transactions and returns completion handshakes.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned WR_LEAD = WR_LEAD_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_stop,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_read_complete,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_b2_empty,
  output logic              o_start_next_write,
  output logic              o_write_complete,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_read,
  output logic              o_avm_write,
  output logic [DATA_W-1:0] o_avm_writedata,
  input  logic              i_avm_waitrequest,
  input  logic [DATA_W-1:0] i_avm_readdata,
  input  logic              i_avm_readdatavalid
);

  localparam int unsigned CNT_W = $clog2(WR_LEAD + 1);

  mac_state_t        state;
  logic              slot_valid;
  logic [ADDR_W-1:0] slot_addr;
  logic              abort_q;
  logic [CNT_W-1:0]  gap_cnt;

  // Single FSM: request sequencing, pending-read slot, error flag and bus outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= IDLE;
      slot_valid         <= 1'b0;
      slot_addr          <= '0;
      abort_q            <= 1'b0;
      gap_cnt            <= '0;
      o_rdata            <= '0;
      o_read_complete    <= 1'b0;
      o_start_next_write <= 1'b0;
      o_write_complete   <= 1'b0;
      o_err              <= 1'b0;
      o_avm_address      <= '0;
      o_avm_read         <= 1'b0;
      o_avm_write        <= 1'b0;
      o_avm_writedata    <= '0;
    end else begin
      o_read_complete    <= 1'b0;
      o_start_next_write <= 1'b0;
      o_write_complete   <= 1'b0;

      if (i_we && (state != WR_ARM)) o_err <= 1'b1;

      // Reads arriving outside IDLE park in the slot; the state case below may
      // override the slot when it is consumed or cleared by a stop.
      if (i_re && (state != IDLE)) begin
        if (slot_valid) begin
          o_err <= 1'b1;
        end else begin
          slot_valid <= 1'b1;
          slot_addr  <= i_raddr;
        end
      end

      case (state)
        IDLE: begin
          if (i_stop) begin
            slot_valid <= 1'b0;
          end else if (slot_valid) begin
            o_avm_address <= slot_addr;
            o_avm_read    <= 1'b1;
            state         <= RD_CMD;
            slot_valid    <= i_re;
            slot_addr     <= i_raddr;
          end else if (i_re) begin
            o_avm_address <= i_raddr;
            o_avm_read    <= 1'b1;
            state         <= RD_CMD;
          end else if (!i_b2_empty) begin
            o_start_next_write <= 1'b1;
            state              <= WR_ARM;
          end
        end

        RD_CMD: begin
          if (i_stop) abort_q <= 1'b1;
          if (!i_avm_waitrequest) begin
            o_avm_read <= 1'b0;
            state      <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (i_stop) abort_q <= 1'b1;
          if (i_avm_readdatavalid) begin
            if (abort_q || i_stop) begin
              abort_q    <= 1'b0;
              slot_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              o_rdata         <= i_avm_readdata;
              o_read_complete <= 1'b1;
              state           <= RD_DONE;
            end
          end
        end

        RD_DONE: begin
          if (i_stop) slot_valid <= 1'b0;
          state <= IDLE;
        end

        WR_ARM: begin
          if (i_stop) begin
            slot_valid <= 1'b0;
            state      <= IDLE;
          end else if (i_we) begin
            o_avm_address   <= i_waddr;
            o_avm_writedata <= i_wdata;
            o_avm_write     <= 1'b1;
            state           <= WR_CMD;
          end
        end

        WR_CMD: begin
          if (i_stop) abort_q <= 1'b1;
          if (!i_avm_waitrequest) begin
            o_avm_write <= 1'b0;
            if (abort_q || i_stop) begin
              abort_q    <= 1'b0;
              slot_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              o_write_complete <= 1'b1;
              state            <= WR_DONE;
            end
          end
        end

        WR_DONE: begin
          if (i_stop) begin
            slot_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            gap_cnt <= CNT_W'(WR_LEAD);
            state   <= WR_GAP;
          end
        end

        WR_GAP: begin
          if (i_stop) begin
            slot_valid <= 1'b0;
            gap_cnt    <= '0;
            state      <= IDLE;
          end else if (gap_cnt <= CNT_W'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a configurable Avalon slave model.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LEAD = 5;

  logic          tb_clk;
  logic          n_rst;
  logic          i_stop, i_re, i_we, i_b2_empty;
  logic [AW-1:0] i_raddr, i_waddr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata;
  logic          o_read_complete, o_start_next_write, o_write_complete, o_err;
  logic [AW-1:0] o_avm_address;
  logic          o_avm_read, o_avm_write;
  logic [DW-1:0] o_avm_writedata;
  logic          avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0] avm_readdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cmd_cnt = 0, rc_cnt = 0, wc_cnt = 0, offer_cnt = 0, rdv_seen = 0;
  int last_rd_cmd_cyc = 0, last_wc_cyc = 0;

  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] rd_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_LEAD(LEAD)) dut (
    .clk(tb_clk), .n_rst(n_rst), .i_stop(i_stop),
    .i_re(i_re), .i_raddr(i_raddr), .o_rdata(o_rdata), .o_read_complete(o_read_complete),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_b2_empty(i_b2_empty),
    .o_start_next_write(o_start_next_write), .o_write_complete(o_write_complete), .o_err(o_err),
    .o_avm_address(o_avm_address), .o_avm_read(o_avm_read), .o_avm_write(o_avm_write),
    .o_avm_writedata(o_avm_writedata), .i_avm_waitrequest(avm_waitrequest),
    .i_avm_readdata(avm_readdata), .i_avm_readdatavalid(avm_readdatavalid)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  always_ff @(posedge tb_clk) cyc <= cyc + 1;

  // Slave model: stalls each command for wait_cycles, returns read data rd_lat cycles after acceptance.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int wait_cycles = 0;
  int rd_lat = 1;
  int wcnt, rdv_cnt;
  logic [DW-1:0] rd_hold;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  assign avm_waitrequest   = (o_avm_read || o_avm_write) && (wcnt < wait_cycles);
  assign avm_readdatavalid = (rdv_cnt == 1);
  assign avm_readdata      = rd_hold;

  always_ff @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst) begin
      wcnt    <= 0;
      rdv_cnt <= 0;
      rd_hold <= '0;
    end else begin
      if ((o_avm_read || o_avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (rdv_cnt > 0) rdv_cnt <= rdv_cnt - 1;
      if (o_avm_read && !avm_waitrequest) begin
        rdv_cnt <= rd_lat;
        rd_hold <= slave_data(o_avm_address);
      end
    end
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Bus-side scoreboard: compares accepted commands and read completions against the queues.
  task automatic monitor();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    forever begin
      @(negedge tb_clk);
      if (n_rst) begin
        if (o_avm_read && !avm_waitrequest) begin
          rd_cmd_cnt++;
          last_rd_cmd_cyc = cyc;
          n_cmp++;
          if (rd_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_cmd: unexpected read, address %h", o_avm_address);
          end else begin
            ea = rd_addr_q.pop_front();
            if (o_avm_address !== ea) begin
              n_err++;
              $display("FAIL rd_cmd_addr: got %h expected %h", o_avm_address, ea);
            end
          end
        end
        if (o_avm_write && !avm_waitrequest) begin
          n_cmp++;
          if (wr_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_cmd: unexpected write, address %h", o_avm_address);
          end else begin
            ea = wr_addr_q.pop_front();
            ed = wr_data_q.pop_front();
            if ((o_avm_address !== ea) || (o_avm_writedata !== ed)) begin
              n_err++;
              $display("FAIL wr_cmd: got %h/%h expected %h/%h", o_avm_address, o_avm_writedata, ea, ed);
            end
          end
        end
        if (avm_readdatavalid) rdv_seen++;
        if (o_read_complete) begin
          rc_cnt++;
          n_cmp++;
          if (rd_data_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_complete: unexpected completion, rdata %h", o_rdata);
          end else begin
            ed = rd_data_q.pop_front();
            if (o_rdata !== ed) begin
              n_err++;
              $display("FAIL rd_data: got %h expected %h", o_rdata, ed);
            end
          end
        end
        if (o_write_complete) begin
          wc_cnt++;
          last_wc_cyc = cyc;
        end
        if (o_start_next_write) offer_cnt++;
      end
    end
  endtask

  task automatic wait_offer(input int max, output bit got);
    int i;
    got = 1'b0;
    i = 0;
    while (!got && i < max) begin
      tick();
      if (o_start_next_write) got = 1'b1;
      i++;
    end
  endtask

  task automatic do_reset();
    i_stop = 0; i_re = 0; i_we = 0; i_b2_empty = 1;
    n_rst = 0;
    repeat (2) tick();
    n_rst = 1;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1;
    #2;
    n_rst = 0;
    #1;
    n_cmp++; if (o_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", o_rdata); end
    n_cmp++; if (o_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", o_err); end
    n_cmp++; if ({o_avm_read, o_avm_write} !== 2'b00) begin n_err++; $display("FAIL reset_rw: got %b expected 00", {o_avm_read, o_avm_write}); end
    n_cmp++; if ({o_avm_address, o_avm_writedata} !== '0) begin n_err++; $display("FAIL reset_bus: got %h/%h expected 0/0", o_avm_address, o_avm_writedata); end
    n_cmp++; if ({o_read_complete, o_start_next_write, o_write_complete} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b expected 000", {o_read_complete, o_start_next_write, o_write_complete}); end
    repeat (2) tick();
    n_rst = 1;
    repeat (3) tick();
    n_cmp++; if ({o_start_next_write, o_avm_read, o_avm_write} !== 3'b000) begin n_err++; $display("FAIL idle_quiet: got %b expected 000", {o_start_next_write, o_avm_read, o_avm_write}); end
  endtask

  task automatic test_single_read();
    int lat;
    wait_cycles = 0; rd_lat = 1;
    mem[32'h0000_0100] = 32'hDEAD_BEEF;
    rd_addr_q.push_back(32'h0000_0100);
    rd_data_q.push_back(32'hDEAD_BEEF);
    i_re = 1; i_raddr = 32'h0000_0100;
    tick();
    i_re = 0;
    lat = 1;
    n_cmp++; if ({o_avm_read, o_avm_address} !== {1'b1, 32'h0000_0100}) begin n_err++; $display("FAIL rd_issue: got read=%b addr=%h expected 1/00000100", o_avm_read, o_avm_address); end
    tick();
    lat++;
    n_cmp++; if (o_avm_read !== 1'b0) begin n_err++; $display("FAIL rd_one_cycle: read got %b expected 0", o_avm_read); end
    while (!o_read_complete && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    tick();
    n_cmp++; if ({o_read_complete, o_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL rd_hold: got %b/%h expected 0/deadbeef", o_read_complete, o_rdata); end
  endtask

  task automatic test_write_handshake();
    bit got;
    int nw, wc0, gap, i;
    bit done;
    wait_cycles = 2;
    wc0 = wc_cnt;
    i_b2_empty = 0;
    wait_offer(10, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL wr_offer: got none expected pulse"); end
    i_we = 1; i_waddr = 32'h0004_0000; i_wdata = 32'h0000_00FF;
    wr_addr_q.push_back(32'h0004_0000);
    wr_data_q.push_back(32'h0000_00FF);
    tick();
    i_we = 0;
    nw = 0; done = 0; i = 0;
    while (!done && i < 20) begin
      if (o_avm_write) nw++;
      if (o_write_complete) done = 1; else tick();
      i++;
    end
    n_cmp++; if (nw != 3) begin n_err++; $display("FAIL wr_hold: write high %0d cycles expected 3", nw); end
    gap = 0; got = 0;
    while (!got && gap < 30) begin tick(); gap++; if (o_start_next_write) got = 1; end
    n_cmp++; if (!got || gap <= int'(LEAD)) begin n_err++; $display("FAIL wr_gap: got gap %0d (seen %0b) expected > %0d", gap, got, LEAD); end
    n_cmp++; if (wc_cnt - wc0 != 1) begin n_err++; $display("FAIL wr_complete_cnt: got %0d expected 1", wc_cnt - wc0); end
    // release the pending offer with a stop
    i_stop = 1; i_b2_empty = 1;
    tick();
    i_stop = 0;
    repeat (8) tick();
    n_cmp++; if (wc_cnt - wc0 != 1) begin n_err++; $display("FAIL stop_arm: completions got %0d expected 1", wc_cnt - wc0); end
    wait_cycles = 0;
  endtask

  task automatic test_nine_writes();
    bit got, fail;
    int wc0, of0, k;
    logic [DW-1:0] d;
    wc0 = wc_cnt; of0 = offer_cnt;
    wait_cycles = 0;
    i_b2_empty = 0;
    fail = 0; k = 0;
    while (!fail && k < 9) begin
      wait_offer(40, got);
      if (!got) begin
        fail = 1;
        n_cmp++; n_err++;
        $display("FAIL nine_offer: offer %0d got none expected pulse", k);
      end else begin
        d = $urandom;
        i_we = 1; i_waddr = 32'h0000_1000 + 32'(k * 4); i_wdata = d;
        wr_addr_q.push_back(i_waddr);
        wr_data_q.push_back(d);
        if (k == 8) i_b2_empty = 1;
        tick();
        i_we = 0;
      end
      k++;
    end
    repeat (30) tick();
    n_cmp++; if (wc_cnt - wc0 != 9) begin n_err++; $display("FAIL nine_completes: got %0d expected 9", wc_cnt - wc0); end
    n_cmp++; if (offer_cnt - of0 != 9) begin n_err++; $display("FAIL nine_offers: got %0d expected 9", offer_cnt - of0); end
  endtask

  task automatic test_read_in_wr_arm();
    bit got;
    int rc0, i;
    rc0 = rc_cnt;
    i_b2_empty = 0;
    wait_offer(10, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL arm_offer: got none expected pulse"); end
    i_re = 1; i_raddr = 32'h0000_0200; i_b2_empty = 1;
    rd_addr_q.push_back(32'h0000_0200);
    rd_data_q.push_back(slave_data(32'h0000_0200));
    tick();
    i_re = 0;
    repeat (2) tick();
    i_we = 1; i_waddr = 32'h0008_0000; i_wdata = 32'h0000_1234;
    wr_addr_q.push_back(32'h0008_0000);
    wr_data_q.push_back(32'h0000_1234);
    tick();
    i_we = 0;
    i = 0;
    while (rc_cnt == rc0 && i < 40) begin tick(); i++; end
    tick();
    n_cmp++; if (rc_cnt - rc0 != 1) begin n_err++; $display("FAIL arm_read_done: got %0d completions expected 1", rc_cnt - rc0); end
    n_cmp++; if (last_rd_cmd_cyc <= last_wc_cyc) begin n_err++; $display("FAIL arm_order: read cmd cycle %0d, write complete cycle %0d, expected read later", last_rd_cmd_cyc, last_wc_cyc); end
    n_cmp++; if (o_err !== 1'b0) begin n_err++; $display("FAIL arm_err: got %b expected 0", o_err); end
  endtask

  task automatic test_overrun();
    int rc0, rd0, i;
    rc0 = rc_cnt; rd0 = rd_cmd_cnt;
    rd_lat = 10;
    i_re = 1; i_raddr = 32'h0000_0400;
    rd_addr_q.push_back(32'h0000_0400); rd_data_q.push_back(slave_data(32'h0000_0400));
    tick();
    i_re = 0;
    tick();
    i_re = 1; i_raddr = 32'h0000_0404;
    rd_addr_q.push_back(32'h0000_0404); rd_data_q.push_back(slave_data(32'h0000_0404));
    tick();
    n_cmp++; if (o_err !== 1'b0) begin n_err++; $display("FAIL ovr_first: err got %b expected 0", o_err); end
    i_raddr = 32'h0000_0408;
    tick();
    i_re = 0;
    n_cmp++; if (o_err !== 1'b1) begin n_err++; $display("FAIL ovr_err: got %b expected 1", o_err); end
    i = 0;
    while (rc_cnt - rc0 < 2 && i < 80) begin tick(); i++; end
    repeat (20) tick();
    n_cmp++; if (rc_cnt - rc0 != 2) begin n_err++; $display("FAIL ovr_completes: got %0d expected 2", rc_cnt - rc0); end
    n_cmp++; if (rd_cmd_cnt - rd0 != 2) begin n_err++; $display("FAIL ovr_reads: got %0d expected 2", rd_cmd_cnt - rd0); end
    rd_lat = 1;
    do_reset();
    n_cmp++; if (o_err !== 1'b0) begin n_err++; $display("FAIL ovr_err_clr: got %b expected 0", o_err); end
    i_we = 1; i_waddr = 32'h0000_0ABC; i_wdata = 32'h1;
    tick();
    i_we = 0;
    n_cmp++; if (o_err !== 1'b1) begin n_err++; $display("FAIL unsol_we: err got %b expected 1", o_err); end
    repeat (3) tick();
    n_cmp++; if ({o_avm_write, o_start_next_write} !== 2'b00) begin n_err++; $display("FAIL unsol_ignored: got %b expected 00", {o_avm_write, o_start_next_write}); end
  endtask

  task automatic test_stop_mid_read();
    int rc0, rdv0;
    do_reset();
    rc0 = rc_cnt; rdv0 = rdv_seen;
    rd_lat = 4;
    i_re = 1; i_raddr = 32'h0000_0300;
    rd_addr_q.push_back(32'h0000_0300);
    tick();
    i_re = 0;
    tick();
    i_stop = 1;
    repeat (6) tick();
    n_cmp++; if (rdv_seen - rdv0 != 1) begin n_err++; $display("FAIL stop_bus: readdatavalid seen %0d expected 1", rdv_seen - rdv0); end
    n_cmp++; if (rc_cnt - rc0 != 0) begin n_err++; $display("FAIL stop_no_complete: got %0d expected 0", rc_cnt - rc0); end
    n_cmp++; if (o_avm_read !== 1'b0) begin n_err++; $display("FAIL stop_read_low: got %b expected 0", o_avm_read); end
    i_stop = 0; i_b2_empty = 0;
    tick();
    n_cmp++; if (o_start_next_write !== 1'b1) begin n_err++; $display("FAIL stop_idle: offer got %b expected 1", o_start_next_write); end
    i_stop = 1; i_b2_empty = 1;
    tick();
    i_stop = 0;
    rd_lat = 1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_write();
    bit got;
    wait_cycles = 6;
    i_b2_empty = 0;
    wait_offer(10, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL rmw_offer: got none expected pulse"); end
    i_we = 1; i_waddr = 32'hCAFE_0000; i_wdata = 32'hA5A5_A5A5;
    tick();
    i_we = 0; i_b2_empty = 1;
    tick();
    n_cmp++; if ({o_avm_write, o_avm_address} !== {1'b1, 32'hCAFE_0000}) begin n_err++; $display("FAIL rmw_cmd: got %b/%h expected 1/cafe0000", o_avm_write, o_avm_address); end
    #2;
    n_rst = 0;
    #1;
    n_cmp++; if ({o_avm_write, o_avm_read, o_avm_address, o_avm_writedata} !== '0) begin n_err++; $display("FAIL rmw_bus: got %b%b/%h/%h expected all 0", o_avm_write, o_avm_read, o_avm_address, o_avm_writedata); end
    n_cmp++; if ({o_rdata, o_err, o_read_complete, o_start_next_write, o_write_complete} !== '0) begin n_err++; $display("FAIL rmw_outs: got %h/%b%b%b%b expected all 0", o_rdata, o_err, o_read_complete, o_start_next_write, o_write_complete); end
    tick();
    n_rst = 1;
    wait_cycles = 0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    i_stop = 0; i_re = 0; i_we = 0; i_b2_empty = 1;
    i_raddr = '0; i_waddr = '0; i_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_write_handshake();
    test_nine_writes();
    test_read_in_wr_arm();
    test_overrun();
    test_stop_mid_read();
    test_reset_mid_write();
    repeat (3) tick();
    n_cmp++; if (rd_addr_q.size() + rd_data_q.size() != 0) begin n_err++; $display("FAIL rd_queue_left: got %0d entries expected 0", rd_addr_q.size() + rd_data_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL wr_queue_left: got %0d entries expected 0", wr_addr_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
